// File: rtl/ram_1p_arb_ctrl.sv
// Two-host round-robin front end for a single-port RAM. Zero-fills the array
// after reset, then arbitrates hosts A and B onto the one port with a 1-cycle read return.
module ram_1p_arb_ctrl #(
  parameter int Width = 39,
  parameter int Depth = 32768,
  localparam int Aw = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             a_req_i,
  input  logic             a_we_i,
  input  logic [Aw-1:0]    a_addr_i,
  input  logic [Width-1:0] a_wdata_i,
  input  logic [Width-1:0] a_wmask_i,
  output logic             a_gnt_o,
  output logic             a_rvalid_o,
  output logic [Width-1:0] a_rdata_o,
  input  logic             b_req_i,
  input  logic             b_we_i,
  input  logic [Aw-1:0]    b_addr_i,
  input  logic [Width-1:0] b_wdata_i,
  input  logic [Width-1:0] b_wmask_i,
  output logic             b_gnt_o,
  output logic             b_rvalid_o,
  output logic [Width-1:0] b_rdata_o,
  output logic             ram_req_o,
  output logic             ram_write_o,
  output logic [Aw-1:0]    ram_addr_o,
  output logic [Width-1:0] ram_wdata_o,
  output logic [Width-1:0] ram_wmask_o,
  input  logic [Width-1:0] ram_rdata_i,
  output logic             init_done_o
);

  typedef enum logic {
    StInit = 1'b0,
    StRun  = 1'b1
  } state_e;

  localparam logic [Aw-1:0] LastAddr = Aw'(Depth - 1);

  state_e          state_q, state_d;
  logic [Aw-1:0]   init_cnt_q, init_cnt_d;
  logic            rr_q, rr_d;        // 0: A has priority, 1: B has priority
  logic            rd_a_q, rd_a_d;
  logic            rd_b_q, rd_b_d;

  // State register and per-cycle bookkeeping
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StInit;
      init_cnt_q <= '0;
      rr_q       <= 1'b0;
      rd_a_q     <= 1'b0;
      rd_b_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      rr_q       <= rr_d;
      rd_a_q     <= rd_a_d;
      rd_b_q     <= rd_b_d;
    end
  end

  // Next-state: walk the init counter to the last word without wrapping
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    case (state_q)
      StInit: begin
        if (init_cnt_q == LastAddr) begin
          state_d = StRun;
        end else begin
          init_cnt_d = init_cnt_q + Aw'(1);
        end
      end
      StRun: begin
        state_d = StRun;
      end
      default: begin
        state_d    = StInit;
        init_cnt_d = '0;
      end
    endcase
  end

  // Outputs: zero-fill writes in INIT, round-robin grant and RAM mux in RUN
  always_comb begin
    a_gnt_o     = 1'b0;
    b_gnt_o     = 1'b0;
    ram_req_o   = 1'b0;
    ram_write_o = 1'b0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    ram_wmask_o = '0;
    rr_d        = rr_q;
    rd_a_d      = 1'b0;
    rd_b_d      = 1'b0;
    case (state_q)
      StInit: begin
        ram_req_o   = 1'b1;
        ram_write_o = 1'b1;
        ram_addr_o  = init_cnt_q;
        ram_wmask_o = '1;
      end
      StRun: begin
        a_gnt_o = a_req_i && (!b_req_i || !rr_q);
        b_gnt_o = b_req_i && (!a_req_i || rr_q);
        if (a_gnt_o) begin
          ram_req_o   = 1'b1;
          ram_write_o = a_we_i;
          ram_addr_o  = a_addr_i;
          ram_wdata_o = a_wdata_i;
          ram_wmask_o = a_wmask_i;
          rr_d        = 1'b1;
          rd_a_d      = !a_we_i;
        end else if (b_gnt_o) begin
          ram_req_o   = 1'b1;
          ram_write_o = b_we_i;
          ram_addr_o  = b_addr_i;
          ram_wdata_o = b_wdata_i;
          ram_wmask_o = b_wmask_i;
          rr_d        = 1'b0;
          rd_b_d      = !b_we_i;
        end else begin
          ram_req_o = 1'b0;
        end
      end
      default: begin
        ram_req_o = 1'b0;
      end
    endcase
  end

  // The RAM's rdata is already registered, so it is steered straight to the read owner
  assign a_rvalid_o  = rd_a_q;
  assign b_rvalid_o  = rd_b_q;
  assign a_rdata_o   = rd_a_q ? ram_rdata_i : '0;
  assign b_rdata_o   = rd_b_q ? ram_rdata_i : '0;
  assign init_done_o = (state_q == StRun);

endmodule
